// File: rtl/arf_pkg.sv
// Shared definitions for the ARF fixed-point arithmetic unit: op codes, default widths and
// a width-generic saturation helper.
package arf_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_FRAC_W   = 12;
  localparam int unsigned DEF_MUL_IN_W = 16;

  localparam logic [DEF_DATA_W-1:0] MAX_S = 32'h7FFF_FFFF;
  localparam logic [DEF_DATA_W-1:0] MIN_S = 32'h8000_0000;

  // Wide enough to hold any sign-extended product or sum of the supported widths.
  localparam int unsigned WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t val;
  } sat_t;

  // Range-checks v against the signed w-bit range; clamps when sat is set, otherwise the
  // caller's truncation to w bits wraps.
  function automatic sat_t saturate(input wide_t v, input int unsigned w, input logic sat);
    sat_t  r;
    wide_t hi;
    wide_t lo;
    hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo    = ~hi;
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.ovf = 1'b1;
      if (sat) r.val = hi;
    end else if (v < lo) begin
      r.ovf = 1'b1;
      if (sat) r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/AMA_appr4_32bit_8appr.sv
// Approximate adder core: the low K bits use approximate mirror adder cell 4
// (sum = ~a | (b & c), carry-out = a); the upper bits are an exact ripple sum.
module AMA_appr4_32bit_8appr #(
  parameter int unsigned W = 32,
  parameter int unsigned K = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);

  logic [K-1:0] w_carry;
  logic [K-1:0] w_lo;

  // Each cell's carry-out is simply its own a input.
  assign w_carry = {i_a[K-2:0], i_cin};
  assign w_lo    = ~i_a[K-1:0] | (i_b[K-1:0] & w_carry);
  assign o_sum   = {i_a[W-1:K] + i_b[W-1:K] + (W-K)'(i_a[K-1]), w_lo};

endmodule

// File: rtl/Multiplier_appr.sv
// Approximate signed multiplier core: the two operand LSBs are dropped before an exact
// W x W signed product.
module Multiplier_appr #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  localparam logic [W-1:0] TRUNC_MASK = ~W'(3);

  logic signed [2*W-1:0] w_a;
  logic signed [2*W-1:0] w_b;

  assign w_a = $signed({{W{i_a[W-1]}}, i_a & TRUNC_MASK});
  assign w_b = $signed({{W{i_b[W-1]}}, i_b & TRUNC_MASK});
  assign o_p = w_a * w_b;

endmodule

// File: rtl/arf_fx_mul_sel.sv
// Stage-2 multiplier: selects the approximate core or the exact product, applies the
// fixed-point shift and, on the exact path only, saturation/overflow detection.
module arf_fx_mul_sel
  import arf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned FRAC_W   = DEF_FRAC_W,
  parameter int unsigned MUL_IN_W = DEF_MUL_IN_W,
  parameter bit          SAT      = 1'b1
) (
  input  logic              i_appr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_prod,
  output logic              o_ovf
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned AW = 2 * MUL_IN_W;

  logic signed [PW-1:0] w_full;
  logic signed [PW-1:0] w_full_sh;
  logic        [AW-1:0] w_appr_p;
  logic signed [PW-1:0] w_appr_ext;
  sat_t                 w_sat;

  assign w_full    = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a})
                   * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
  assign w_full_sh = w_full >>> FRAC_W;
  assign w_sat     = saturate({{(WIDE_W-PW){w_full_sh[PW-1]}}, w_full_sh}, DATA_W, SAT);

  Multiplier_appr #(
    .W (MUL_IN_W)
  ) u_mul_appr (
    .i_a (i_a[MUL_IN_W-1:0]),
    .i_b (i_b[MUL_IN_W-1:0]),
    .o_p (w_appr_p)
  );

  assign w_appr_ext = $signed({{(PW-AW){w_appr_p[AW-1]}}, w_appr_p});

  // The shifted approximate product always fits, so that path never flags overflow.
  always_comb begin
    o_prod = '0;
    o_ovf  = 1'b0;
    if (i_appr) begin
      o_prod = DATA_W'(w_appr_ext >>> FRAC_W);
    end else begin
      o_prod = DATA_W'(w_sat.val);
      o_ovf  = w_sat.ovf;
    end
  end

endmodule

// File: rtl/arf_fx_mac.sv
// ARF fixed-point arithmetic unit: 3-stage valid/ready MUL/ADD/MAC/CLR pipeline with a
// tag pass-through, internal accumulator, optional saturation and sticky overflow flag.
module arf_fx_mac
  import arf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned FRAC_W   = DEF_FRAC_W,
  parameter int unsigned MUL_IN_W = DEF_MUL_IN_W,
  parameter int unsigned TAG_W    = 8,
  parameter bit          SAT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_mul_appr,
  input  logic              in_add_appr,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ovf
);

  logic              w_adv;

  logic              r_s1_valid;
  op_e               r_s1_op;
  logic              r_s1_mul_appr;
  logic              r_s1_add_appr;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  op_e               r_s2_op;
  logic              r_s2_add_appr;
  logic [DATA_W-1:0] r_s2_a;
  logic [DATA_W-1:0] r_s2_b;
  logic [DATA_W-1:0] r_s2_prod;
  logic              r_s2_prod_ovf;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_ovf;
  logic [DATA_W-1:0] r_acc;

  logic [DATA_W-1:0] w_prod;
  logic              w_prod_ovf;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  wide_t             w_sum_wide;
  sat_t              w_add_sat;
  logic [DATA_W-1:0] w_appr_sum;
  logic [DATA_W-1:0] w_res;
  logic              w_res_ovf;

  // The whole pipeline moves together; it only holds while a result is refused.
  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_op       <= OP_MUL;
      r_s1_mul_appr <= 1'b0;
      r_s1_add_appr <= 1'b0;
      r_s1_a        <= '0;
      r_s1_b        <= '0;
      r_s1_tag      <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op       <= op_e'(in_op);
        r_s1_mul_appr <= in_mul_appr;
        r_s1_add_appr <= in_add_appr;
        r_s1_a        <= in_a;
        r_s1_b        <= in_b;
        r_s1_tag      <= in_tag;
      end
    end
  end

  arf_fx_mul_sel #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .MUL_IN_W (MUL_IN_W),
    .SAT      (SAT)
  ) u_mul_sel (
    .i_appr (r_s1_mul_appr),
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_prod (w_prod),
    .o_ovf  (w_prod_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_s2_op       <= OP_MUL;
      r_s2_add_appr <= 1'b0;
      r_s2_a        <= '0;
      r_s2_b        <= '0;
      r_s2_prod     <= '0;
      r_s2_prod_ovf <= 1'b0;
      r_s2_tag      <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_op       <= r_s1_op;
        r_s2_add_appr <= r_s1_add_appr;
        r_s2_a        <= r_s1_a;
        r_s2_b        <= r_s1_b;
        r_s2_prod     <= w_prod;
        r_s2_prod_ovf <= w_prod_ovf && (r_s1_op == OP_MUL || r_s1_op == OP_MAC);
        r_s2_tag      <= r_s1_tag;
      end
    end
  end

  // Stage-3 adder operands: ADD uses the raw operands, MAC adds the product to the acc.
  always_comb begin
    w_x = r_s2_a;
    w_y = r_s2_b;
    if (r_s2_op == OP_MAC) begin
      w_x = r_acc;
      w_y = r_s2_prod;
    end
  end

  assign w_sum_wide = $signed({{(WIDE_W-DATA_W){w_x[DATA_W-1]}}, w_x})
                    + $signed({{(WIDE_W-DATA_W){w_y[DATA_W-1]}}, w_y});
  assign w_add_sat  = saturate(w_sum_wide, DATA_W, SAT);

  AMA_appr4_32bit_8appr #(
    .W (DATA_W),
    .K (8)
  ) u_add_appr (
    .i_a   (w_x),
    .i_b   (w_y),
    .i_cin (1'b0),
    .o_sum (w_appr_sum)
  );

  always_comb begin
    w_res     = '0;
    w_res_ovf = 1'b0;
    unique case (r_s2_op)
      OP_MUL: begin
        w_res     = r_s2_prod;
        w_res_ovf = r_s2_prod_ovf;
      end
      OP_ADD, OP_MAC: begin
        if (r_s2_add_appr) begin
          w_res     = w_appr_sum;
          w_res_ovf = r_s2_prod_ovf;
        end else begin
          w_res     = DATA_W'(w_add_sat.val);
          w_res_ovf = w_add_sat.ovf || r_s2_prod_ovf;
        end
      end
      OP_CLR: begin
        w_res     = '0;
        w_res_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  // Accumulator and flag only change on a retiring beat, so stalls cannot double-update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= w_res;
        r_out_tag  <= r_s2_tag;
        if (r_s2_op == OP_CLR) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end else begin
          if (r_s2_op == OP_MAC) r_acc <= w_res;
          r_ovf <= r_ovf || w_res_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_arf_fx_mac.sv
// Directed bench for arf_fx_mac: expected results are queued at acceptance from a
// bit-level model and compared as each result beat is taken.
module tb_arf_fx_mac;

  localparam bit         SAT  = 1'b1;
  localparam logic [1:0] T_MUL = 2'b00;
  localparam logic [1:0] T_ADD = 2'b01;
  localparam logic [1:0] T_MAC = 2'b10;
  localparam logic [1:0] T_CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic        in_mul_appr = 1'b0;
  logic        in_add_appr = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_tag;
  logic        ovf;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_ret = 0;
  logic [31:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic [7:0]  tag_ctr = 8'h01;

  arf_fx_mac #(
    .DATA_W   (32),
    .FRAC_W   (12),
    .MUL_IN_W (16),
    .TAG_W    (8),
    .SAT      (SAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_mul_appr (in_mul_appr),
    .in_add_appr (in_add_appr),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed=timeout expected=event", name);
  endtask

  // {ovf, value}
  function automatic logic [32:0] sat32(input longint v);
    if (v > 64'sd2147483647) return {1'b1, SAT ? 32'h7FFF_FFFF : v[31:0]};
    if (v < -64'sd2147483648) return {1'b1, SAT ? 32'h8000_0000 : v[31:0]};
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic appr);
    logic [15:0] ta;
    logic [15:0] tb;
    longint      p;
    if (appr) begin
      ta = a[15:0] & 16'hFFFC;
      tb = b[15:0] & 16'hFFFC;
      p  = longint'($signed(ta)) * longint'($signed(tb));
      p  = p >>> 12;
      return {1'b0, p[31:0]};
    end
    p = longint'($signed(a)) * longint'($signed(b));
    return sat32(p >>> 12);
  endfunction

  function automatic logic [32:0] add_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic appr);
    logic [31:0] s;
    logic        c;
    if (!appr) return sat32(longint'($signed(x)) + longint'($signed(y)));
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = ~x[i] | (y[i] & c);
      c    = x[i];
    end
    s[31:8] = x[31:8] + y[31:8] + {23'b0, c};
    return {1'b0, s};
  endfunction

  task automatic model_push(input logic [1:0] op, input logic ma, input logic aa,
                            input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
    logic [32:0] p;
    logic [32:0] r;
    exp_t        e;
    case (op)
      T_MUL: r = mul_model(a, b, ma);
      T_ADD: r = add_model(a, b, aa);
      T_MAC: begin
        p     = mul_model(a, b, ma);
        r     = add_model(m_acc, p[31:0], aa);
        r[32] = r[32] | p[32];
        m_acc = r[31:0];
      end
      default: begin
        r     = '0;
        m_acc = '0;
        m_ovf = 1'b0;
      end
    endcase
    if (op != T_CLR) m_ovf = m_ovf | r[32];
    e.data = r[31:0];
    e.tag  = tag;
    e.ovf  = m_ovf;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic ma, input logic aa,
                      input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited      = 0;
    in_valid    = 1'b1;
    in_op       = op;
    in_mul_appr = ma;
    in_add_appr = aa;
    in_a        = a;
    in_b        = b;
    in_tag      = tag_ctr;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      timeout_fail("send_accept");
    end else begin
      model_push(op, ma, aa, a, b, tag_ctr);
      tag_ctr = tag_ctr + 8'd1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_result: observed data=%h expected no result", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", 32'(out_tag), 32'(e.tag));
        check("ovf", 32'(ovf), 32'(e.ovf));
        n_ret++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n0;
    logic [1:0]  rop;
    logic        rma;
    logic        raa;

    // Reset values while reset is held and just after release.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready_rel", 32'(in_ready), 32'd1);

    // MUL exact 1.5 * 2.0 and its three-cycle latency.
    send(T_MUL, 1'b0, 1'b0, 32'h0000_1800, 32'h0000_2000);
    check("lat_after_s1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_after_s2", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_after_s3", 32'(out_valid), 32'd1);
    wait_drain();

    // Four back-to-back MACs then CLR.
    n0 = n_ret;
    repeat (4) send(T_MAC, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000);
    send(T_CLR, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_drain();
    check("mac_beats", 32'(n_ret - n0), 32'd5);

    // Exact ADD saturation; ovf sticky across a MUL, cleared by CLR.
    send(T_ADD, 1'b0, 1'b0, 32'h7FFF_FFF0, 32'h0000_0020);
    send(T_MUL, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_1000);
    wait_drain();
    check("ovf_sticky", 32'(ovf), 32'd1);
    send(T_CLR, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_drain();
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Backpressure: out_ready low for four cycles once the first result shows.
    n0 = n_ret;
    fork
      begin
        send(T_CLR, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) send(T_MAC, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000);
      end
      begin
        int          k;
        logic [31:0] held_d;
        logic [7:0]  held_t;
        k = 0;
        @(posedge clk);
        #1;
        while (!out_valid && k < 20) begin
          @(posedge clk);
          #1;
          k++;
        end
        if (!out_valid) begin
          timeout_fail("bp_first_result");
        end else begin
          out_ready = 1'b0;
          held_d    = out_data;
          held_t    = out_tag;
          repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_data_stable", out_data, held_d);
            check("bp_tag_stable", 32'(out_tag), 32'(held_t));
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      end
    join
    wait_drain();
    check("bp_beats", 32'(n_ret - n0), 32'd6);

    // Random ops with at least one approximate path selected.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 2));
      rma = 1'($urandom_range(0, 1));
      raa = 1'($urandom_range(0, 1));
      if (!rma && !raa) raa = 1'b1;
      send(rop, rma, raa, $urandom, $urandom);
    end
    send(T_CLR, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_drain();

    // Asynchronous reset with three MACs in flight.
    repeat (3) send(T_MAC, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000);
    check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_valid_drop", 32'(out_valid), 32'd0);
    check("rst_mid_data", out_data, 32'h0);
    sb.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(T_MAC, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
